// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one fraction multiplier among NREQ requesters.
// Optional macro FP16_MUL_ARB_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT cycles.
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif

module fp16_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int TIMEOUT = 64,
  localparam int FW = `FP16_FRACW,
  localparam int PW = 2 * `FP16_FRACW,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    reqValid,
  output logic [NREQ-1:0]    reqReady,
  input  logic [NREQ*FW-1:0] reqA,
  input  logic [NREQ*FW-1:0] reqB,
  output logic               respValid,
  input  logic               respReady,
  output logic [IDW-1:0]     respId,
  output logic [PW-1:0]      respProduct,
  output logic               respErr,
  output logic [FW-1:0]      mulIn1,
  output logic [FW-1:0]      mulIn2,
  output logic               start,
  input  logic [PW-1:0]      mulOut,
  input  logic               done,
  output logic               busy,
  output logic [1:0]         dbgState
);

  // Handshakes: a request transfers in the cycle reqValid[i] && reqReady[i];
  // a response transfers in the cycle respValid && respReady. Neither ready
  // depends on the same-cycle ready of the other side.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [FW-1:0]     op_a_q, op_a_d;
  logic [FW-1:0]     op_b_q, op_b_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic              grant_vld;
  logic [IDW-1:0]    grant_idx;
  logic [NREQ-1:0]   grant_onehot;
  int                scan_idx;

`ifdef FP16_MUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  // First valid requester at or above rr_ptr, wrapping past NREQ-1.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!grant_vld && reqValid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    prod_d       = prod_q;
    grant_onehot = '0;
`ifdef FP16_MUL_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          grant_onehot[grant_idx] = 1'b1;
          id_d    = grant_idx;
          op_a_d  = reqA[grant_idx*FW +: FW];
          op_b_d  = reqB[grant_idx*FW +: FW];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef FP16_MUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          prod_d  = mulOut;
`ifdef FP16_MUL_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef FP16_MUL_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (respReady) begin
          rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      prod_q   <= '0;
`ifdef FP16_MUL_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      prod_q   <= prod_d;
`ifdef FP16_MUL_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // The accept pulse is combinational from reqValid, so mask it while reset is held.
  assign reqReady    = grant_onehot & {NREQ{reset}};
  assign start       = (state_q == S_ISSUE);
  assign respValid   = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign respId      = id_q;
  assign respProduct = prod_q;
  assign mulIn1      = op_a_q;
  assign mulIn2      = op_b_q;
  assign dbgState    = state_q;
`ifdef FP16_MUL_ARB_TIMEOUT_EN
  assign respErr     = err_q;
`else
  assign respErr     = 1'b0;
`endif

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Bench for fp16_mul_arbiter: directed steps plus random traffic against a
// transaction-level round-robin model and a latency-randomized multiplier stub.
module tb_fp16_mul_arbiter;
  localparam int NREQ = 4;
  localparam int FW   = 10;
  localparam int PW   = 20;
  localparam int IDW  = 2;
  localparam int EW   = IDW + PW + 1;
`ifdef FP16_MUL_ARB_TIMEOUT_EN
  localparam int TMO  = 8;
`else
  localparam int TMO  = 64;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NREQ-1:0]    reqValid, reqReady;
  logic [NREQ*FW-1:0] reqA, reqB;
  logic               respValid, respReady, respErr;
  logic [IDW-1:0]     respId;
  logic [PW-1:0]      respProduct;
  logic [FW-1:0]      mulIn1, mulIn2;
  logic               start, done, busy;
  logic [PW-1:0]      mulOut;
  logic [1:0]         dbgState;

  fp16_mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqA(reqA), .reqB(reqB),
    .respValid(respValid), .respReady(respReady), .respId(respId),
    .respProduct(respProduct), .respErr(respErr),
    .mulIn1(mulIn1), .mulIn2(mulIn2), .start(start),
    .mulOut(mulOut), .done(done), .busy(busy), .dbgState(dbgState)
  );

  // ---------------- multiplier stub ----------------
  int          lat_min = 1, lat_max = 5;
  bit          never_done = 1'b0;
  int          lat_left;
  logic        done_s;
  logic [PW-1:0] prod_r, junk_r;

  function automatic int stub_lat();
    return $urandom_range(lat_max, lat_min);
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_left <= 0;
      done_s   <= 1'b0;
      prod_r   <= '0;
      junk_r   <= '0;
    end else begin
      junk_r <= PW'($urandom);
      done_s <= 1'b0;
      if (start && !never_done) begin
        lat_left <= stub_lat();
        prod_r   <= PW'(int'(mulIn1) * int'(mulIn2));
      end else if (lat_left > 0) begin
        lat_left <= lat_left - 1;
        done_s   <= (lat_left == 1);
      end
    end
  end
  assign done   = done_s;
  assign mulOut = done_s ? prod_r : junk_r;

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int            served_q[$];
  logic [NREQ-1:0] drv_valid;
  logic [FW-1:0]   drv_a [NREQ];
  logic [FW-1:0]   drv_b [NREQ];
  int   rr_m, acc_idx, wait_ticks, resp_mode, served_cnt;
  bit   idle_m, start_exp, resp_exp, waiting, inject;
  logic [FW-1:0] cur_a, cur_b;
  logic [PW-1:0] last_prod;
  logic          last_err;
  int   last_id, rdy_pulses, start_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [FW-1:0] rand_op();
    case ($urandom_range(7, 0))
      0:       return '0;
      1:       return 10'd1023;
      default: return FW'($urandom);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_inputs();
    reqValid = drv_valid;
    for (int i = 0; i < NREQ; i++) begin
      reqA[i*FW +: FW] = drv_a[i];
      reqB[i*FW +: FW] = drv_b[i];
    end
  endtask

  task automatic set_req(input int i, input logic [FW-1:0] a, input logic [FW-1:0] b);
    drv_valid[i] = 1'b1;
    drv_a[i] = a;
    drv_b[i] = b;
    apply_inputs();
  endtask

  task automatic model_init();
    idle_m = 1'b1; rr_m = 0; start_exp = 1'b0; resp_exp = 1'b0;
    waiting = 1'b0; wait_ticks = 0; acc_idx = -1;
    exp_q.delete();
  endtask

  task automatic clear_drv();
    drv_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      drv_a[i] = '0;
      drv_b[i] = '0;
    end
    apply_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_reqReady"}, reqReady, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_respValid"}, respValid, 0);
    check({tag, "_respId"}, respId, 0);
    check({tag, "_respProduct"}, respProduct, 0);
    check({tag, "_respErr"}, respErr, 0);
    check({tag, "_mulIn1"}, mulIn1, 0);
    check({tag, "_mulIn2"}, mulIn2, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One clock: scoreboard checks at negedge, then input updates just after posedge.
  task automatic tick();
    logic [NREQ-1:0] exp_rdy;
    logic [EW-1:0]   e;
    int              g;
    @(negedge clock);
    exp_rdy = '0;
    g = idle_m ? pick(rr_m, drv_valid) : -1;
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (reqReady != '0) rdy_pulses++;
    if (start) start_pulses++;
    check("reqReady", reqReady, exp_rdy);
    check("busy", busy, !idle_m);
    check("start", start, start_exp);
    check("respValid", respValid, resp_exp);
    if (start_exp || waiting) begin
      check("mulIn1", mulIn1, cur_a);
      check("mulIn2", mulIn2, cur_b);
    end
    if (resp_exp) begin
      e = exp_q[0];
      check("respId", respId, e[EW-1 -: IDW]);
      check("respProduct", respProduct, e[PW:1]);
      check("respErr", respErr, e[0]);
      if (respReady) begin
        last_id   = int'(respId);
        last_prod = respProduct;
        last_err  = respErr;
        served_q.push_back(int'(respId));
        rr_m = (int'(e[EW-1 -: IDW]) + 1) % NREQ;
        void'(exp_q.pop_front());
        resp_exp = 1'b0;
        idle_m   = 1'b1;
        served_cnt++;
      end
    end
    if (waiting) begin
      if (done) begin
        waiting  = 1'b0;
        resp_exp = 1'b1;
      end
`ifdef FP16_MUL_ARB_TIMEOUT_EN
      else begin
        wait_ticks++;
        if (wait_ticks == TMO) begin
          waiting  = 1'b0;
          resp_exp = 1'b1;
          e = exp_q[0];
          e[PW:0] = {{PW{1'b0}}, 1'b1};
          exp_q[0] = e;
        end
      end
`endif
    end
    if (start_exp) begin
      start_exp  = 1'b0;
      waiting    = 1'b1;
      wait_ticks = 0;
    end
    if (g >= 0) begin
      idle_m    = 1'b0;
      start_exp = 1'b1;
      cur_a     = drv_a[g];
      cur_b     = drv_b[g];
      exp_q.push_back({IDW'(g), PW'(int'(drv_a[g]) * int'(drv_b[g])), 1'b0});
      acc_idx   = g;
    end
    @(posedge clock);
    #1;
    if (acc_idx >= 0) drv_valid[acc_idx] = 1'b0;
    acc_idx = -1;
    if (inject)
      for (int i = 0; i < NREQ; i++)
        if (!drv_valid[i] && $urandom_range(2, 0) == 0) begin
          drv_valid[i] = 1'b1;
          drv_a[i] = rand_op();
          drv_b[i] = rand_op();
        end
    respReady = (resp_mode == 0) ? 1'b1 :
                (resp_mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
    apply_inputs();
  endtask

  task automatic run_ops(input int n, input int budget);
    int target;
    int cnt;
    target = served_cnt + n;
    cnt = 0;
    while (served_cnt < target && cnt < budget) begin
      tick();
      cnt++;
    end
    if (served_cnt < target) begin
      checks++;
      errors++;
      $error("FAIL run_ops_budget observed=%0d expected=%0d", served_cnt, target);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_drv();
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_init();
  endtask

  // ---------------- directed sequence ----------------
  int r0, s0, cnt;
  initial begin
    reset = 1'b0;
    respReady = 1'b0;
    resp_mode = 0;
    inject = 1'b0;
    served_cnt = 0; rdy_pulses = 0; start_pulses = 0;
    last_prod = '0; last_err = 1'b0; last_id = -1;
    clear_drv();
    model_init();
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    respReady = 1'b1;

    // single request
    r0 = rdy_pulses; s0 = start_pulses;
    set_req(0, 10'd3, 10'd4);
    run_ops(1, 50);
    repeat (2) tick();
    check("single_reqReady_pulses", rdy_pulses - r0, 1);
    check("single_start_pulses", start_pulses - s0, 1);
    check("single_id", last_id, 0);
    check("single_product", last_prod, 12);
    check("single_err", last_err, 0);

    // contention from reset: 0,2 then 1,3 with pointer at 3
    do_reset();
    served_q.delete();
    set_req(0, 10'd17, 10'd19);
    set_req(2, 10'd100, 10'd7);
    run_ops(2, 80);
    set_req(1, 10'd5, 10'd6);
    set_req(3, 10'd512, 10'd2);
    run_ops(2, 80);
    check("contention_count", served_q.size(), 4);
    check("contention_first", served_q[0], 0);
    check("contention_second", served_q[1], 2);
    check("contention_third", served_q[2], 3);
    check("contention_fourth", served_q[3], 1);

    // maximum operands
    set_req(2, 10'd1023, 10'd1023);
    run_ops(1, 50);
    check("max_product", last_prod, 1046529);

    // response backpressure with a competing requester
    resp_mode = 2;
    respReady = 1'b0;
    set_req(1, 10'd37, 10'd55);
    cnt = 0;
    while (!resp_exp && cnt < 40) begin
      tick();
      cnt++;
    end
    check("bp_reached_resp", resp_exp, 1);
    set_req(0, 10'd9, 10'd9);
    r0 = rdy_pulses;
    repeat (10) tick();
    check("bp_no_new_grant", rdy_pulses - r0, 0);
    check("bp_busy", busy, 1);
    resp_mode = 0;
    respReady = 1'b1;
    run_ops(2, 80);
    check("bp_first_served", served_q[served_q.size() - 2], 1);

    // reset in the middle of WAIT
    lat_min = 20; lat_max = 20;
    set_req(3, 10'd100, 10'd200);
    cnt = 0;
    while (!waiting && cnt < 10) begin
      tick();
      cnt++;
    end
    repeat (3) tick();
    check("midwait_waiting", waiting, 1);
    reset = 1'b0;
    #1;
    check_all_zero("midwait");
    model_init();
    clear_drv();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    lat_min = 1; lat_max = 5;
    r0 = served_cnt;
    repeat (25) tick();
    check("midwait_no_resp", served_cnt - r0, 0);
    set_req(1, 10'd11, 10'd13);
    set_req(3, 10'd21, 10'd23);
    run_ops(2, 80);
    check("post_reset_first", served_q[served_q.size() - 2], 1);
    check("post_reset_second", served_q[served_q.size() - 1], 3);

    // random traffic with random backpressure
    resp_mode = 1;
    inject = 1'b1;
    run_ops(40, 3000);
    inject = 1'b0;
    resp_mode = 0;
    cnt = 0;
    while (!(drv_valid == '0 && idle_m && exp_q.size() == 0) && cnt < 500) begin
      tick();
      cnt++;
    end
    check("drain_empty", exp_q.size(), 0);

`ifdef FP16_MUL_ARB_TIMEOUT_EN
    // multiplier that never answers
    never_done = 1'b1;
    set_req(2, 10'd5, 10'd6);
    run_ops(1, 60);
    check("timeout_err", last_err, 1);
    check("timeout_product", last_prod, 0);
    never_done = 1'b0;
    set_req(0, 10'd8, 10'd8);
    run_ops(1, 60);
    check("after_timeout_product", last_prod, 64);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_mul_arbiter.md
# fp16_mul_arbiter

Round-robin arbiter and sequencer that shares one `fpuMultiplier16` (10-bit fraction multiplier, start/done handshake) among `NREQ` requesters in the FP16 datapath. Accepts one operand pair at a time over per-requester valid/ready, drives the multiplier's start pulse, captures the 20-bit product on done, and returns it on a single tagged response port with backpressure. Sits between FPU pipeline stages needing mantissa products and the single shared multiplier instance.

## Interface

- `NREQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, cycles allowed in WAIT before abort (only with `FP16_MUL_ARB_TIMEOUT_EN`)
- `clock`  in  1  system clock, all state on posedge
- `reset`  in  1  asynchronous, active-low reset
- `reqValid`  in  NREQ  requester i has an operand pair
- `reqReady`  out  NREQ  one-hot accept pulse for granted requester
- `reqA`  in  NREQ*`FP16_FRACW`  operand 1, requester i at bits [i*10 +: 10]
- `reqB`  in  NREQ*`FP16_FRACW`  operand 2, same packing
- `respValid`  out  1  product available
- `respReady`  in  1  consumer accepts product
- `respId`  out  $clog2(NREQ)  requester index owning the response
- `respProduct`  out  2*`FP16_FRACW`  unsigned product
- `respErr`  out  1  response is a timeout abort
- `mulIn1`, `mulIn2`  out  `FP16_FRACW`  operands to multiplier, stable from ISSUE through WAIT
- `start`  out  1  one-cycle start pulse to multiplier
- `mulOut`  in  2*`FP16_FRACW`  multiplier product
- `done`  in  1  one-cycle pulse, `mulOut` valid that cycle
- `busy`  out  1  state != IDLE

## Operation

- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `reqValid`, grant g = first set bit searching from `rrPtr` upward with wrap; assert `reqReady[g]` this cycle only; latch `reqA/reqB` slice g into `mulIn1/mulIn2`, latch g as id; go ISSUE. No valid: stay.
- ISSUE: `start`=1 for exactly this cycle; go WAIT.
- WAIT: on `done`, latch `mulOut` into `respProduct`, `respErr`=0; go RESP. `done` in any other state ignored.
- RESP: `respValid`=1, `respId`/`respProduct`/`respErr` held stable until `respValid && respReady`; on that cycle set `rrPtr` = (g+1) mod NREQ, go IDLE.
- Only one operation outstanding; requesters not granted keep `reqValid` and wait.
- Product is zero-extended unsigned; no rounding or normalization here.
- `reqValid` deasserted after a grant is irrelevant; operands already latched.

## Timing

- Reset (async assert, sync-released): state IDLE, `rrPtr`=0, all outputs 0 (`reqReady`, `start`, `respValid`, `respId`, `respProduct`, `respErr`, `mulIn1`, `mulIn2`, `busy`).
- Accept cycle T (IDLE, `reqReady` high); `start` at T+1; multiplier `done` at T+1+L; `respValid` at T+2+L; earliest next accept one cycle after response handshake.
- Overhead beyond multiplier latency L: 3 cycles per operation plus response backpressure.
- Requester i waits at most NREQ-1 other operations once valid (round robin fairness).
- Reset mid-operation aborts with no response; the same `reset` also resets the multiplier, so no stale `done` arrives.

## Configuration

- `FP16_MUL_ARB_TIMEOUT_EN` defined: cycle counter cleared on entering WAIT; if `done` not seen after `TIMEOUT` cycles in WAIT, go RESP with `respProduct`=0, `respErr`=1. A `done` arriving later is ignored in IDLE/ISSUE... except it must not be taken as the next operation's result: the arbiter stays in RESP/IDLE, and a `done` seen in ISSUE is discarded.
- Not defined: no counter; WAIT holds indefinitely until `done`; `respErr` tied 0.

## Test plan

- Single request: requester 0, A=3, B=4, `respReady`=1 -> one `reqReady[0]` pulse, one `start` pulse, `respValid` with `respId`=0, `respProduct`=12, `respErr`=0.
- Contention: requesters 0 and 2 valid together from reset -> served 0 then 2; then requesters 1 and 3 valid with `rrPtr`=3 -> served 3 then 1.
- Max operands: A=B=1023 -> `respProduct`=1046529.
- Backpressure: hold `respReady`=0 for 10 cycles after `respValid` -> outputs stable, no new `reqReady`, `busy`=1; release -> handshake, IDLE next cycle.
- Reset mid-WAIT: deassert `reset` low during WAIT -> all outputs 0 immediately, no response after release, next request served normally from `rrPtr`=0.
- With `FP16_MUL_ARB_TIMEOUT_EN`, TIMEOUT=8, multiplier stub never pulses `done` -> `respValid` with `respErr`=1, `respProduct`=0, 8 cycles after WAIT entry.
